burst_bit_serializer: RTL and testbench

Downstream consumer of the burst gate produced by the burst timing stage (gate high = on-air window).
- On each rising edge of the gate, serializes an 8-bit preamble followed by payload bytes taken over a valid/ready interface. Bits go LSB first at a fixed number of clock cycles per bit.
- Ends the burst when payload runs out or the gate drops.
- Output bit stream feeds the modulator / pin driver.

---
 rtl/burst_pkg.sv | 16 +
 rtl/burst_crc8.sv | 20 ++
 rtl/burst_bit_serializer.sv | 160 ++++++++++++++++
 tb/tb_burst_bit_serializer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and constants for the burst bit serializer.
// CRC-related items are only used when BURST_SERIALIZER_CRC_EN is defined.
package burst_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StData,
      StCrc,
      StGuard
   } state_e;

   localparam logic [7:0] CRC8_POLY        = 8'h07;
   localparam logic [7:0] PREAMBLE_DEFAULT = 8'hAA;

endpackage

// File: rtl/burst_crc8.sv
// Combinational CRC-8 update: one whole byte folded in, MSB first, poly CRC8_POLY.
// Only instantiated when BURST_SERIALIZER_CRC_EN is defined.
module burst_crc8
   import burst_pkg::*;
(
   input  logic [7:0] crc,
   input  logic [7:0] data,
   output logic [7:0] crc_next
);

   always_comb begin
      logic [7:0] acc;
      acc = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         acc = acc[7] ? ((acc << 1) ^ CRC8_POLY) : (acc << 1);
      end
      crc_next = acc;
   end

endmodule

// File: rtl/burst_bit_serializer.sv
// Serializes preamble + payload bytes (LSB first, BIT_DIV clocks per bit) inside a burst gate.
// Define BURST_SERIALIZER_CRC_EN to append a CRC-8 byte after the last payload byte.
module burst_bit_serializer
   import burst_pkg::*;
#(
   parameter int unsigned BIT_DIV      = 100,
   parameter logic [7:0]  PREAMBLE_PAT = PREAMBLE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       burst_en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx_bit,
   output logic       tx_active,
   output logic       bit_strobe,
   output logic       trunc
);

   localparam int unsigned    DivW    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);

   state_e          state_q, state_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            burst_en_q;
   logic            tx_bit_q, tx_active_q, bit_strobe_q, trunc_q;
   logic            trunc_d, active_d;
   logic            start, bit_end, byte_end;

`ifdef BURST_SERIALIZER_CRC_EN
   logic [7:0] crc_q, crc_d, crc_next;

   burst_crc8 u_crc8 (
      .crc      (crc_q),
      .data     (in_data),
      .crc_next (crc_next)
   );
`endif

   always_comb begin
      start    = burst_en && !burst_en_q;
      bit_end  = (div_cnt_q == DivLast);
      byte_end = bit_end && (bit_cnt_q == 3'd7);
      // Depends on burst_en so nothing is accepted in an aborting cycle.
      in_ready = byte_end && burst_en && ((state_q == StPre) || (state_q == StData));
   end

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      trunc_d   = 1'b0;
`ifdef BURST_SERIALIZER_CRC_EN
      crc_d     = crc_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StPre;
               shift_d   = PREAMBLE_PAT;
               div_cnt_d = '0;
               bit_cnt_d = '0;
`ifdef BURST_SERIALIZER_CRC_EN
               crc_d     = '0;
`endif
            end
         end

         StPre, StData, StCrc: begin
            if (!burst_en) begin
               state_d   = StIdle;
               trunc_d   = 1'b1;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end else if (bit_end) begin
               div_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + 3'd1;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  if (in_ready && in_valid) begin
                     state_d = StData;
                     shift_d = in_data;
`ifdef BURST_SERIALIZER_CRC_EN
                     crc_d   = crc_next;
`endif
                  end else if (state_q == StData) begin
`ifdef BURST_SERIALIZER_CRC_EN
                     state_d = StCrc;
                     shift_d = crc_q;
`else
                     state_d = StGuard;
`endif
                  end else begin
                     // Preamble with no payload, or the CRC byte just finished.
                     state_d = StGuard;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         StGuard: begin
            if (!burst_en) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      // Outputs are registered from next-state so they line up with the bit being sent.
      active_d = (state_d == StPre) || (state_d == StData) || (state_d == StCrc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         burst_en_q   <= 1'b1;
         tx_bit_q     <= 1'b0;
         tx_active_q  <= 1'b0;
         bit_strobe_q <= 1'b0;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         burst_en_q   <= burst_en;
         tx_bit_q     <= active_d && shift_d[0];
         tx_active_q  <= active_d;
         bit_strobe_q <= active_d && (div_cnt_d == '0);
         trunc_q      <= trunc_d;
      end
   end

`ifdef BURST_SERIALIZER_CRC_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end
`endif

   assign tx_bit     = tx_bit_q;
   assign tx_active  = tx_active_q;
   assign bit_strobe = bit_strobe_q;
   assign trunc      = trunc_q;

endmodule

// File: tb/tb_burst_bit_serializer.sv
// Directed bench for burst_bit_serializer at BIT_DIV = 4.
// Observed vector per cycle: {tx_active, tx_bit, bit_strobe, in_ready, trunc}.
module tb_burst_bit_serializer;

   localparam int unsigned BIT_DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       burst_en;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_bit;
   logic       tx_active;
   logic       bit_strobe;
   logic       trunc;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   burst_bit_serializer #(
      .BIT_DIV      (BIT_DIV),
      .PREAMBLE_PAT (8'hAA)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .burst_en   (burst_en),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_bit     (tx_bit),
      .tx_active  (tx_active),
      .bit_strobe (bit_strobe),
      .trunc      (trunc)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst      = 1'b1;
      burst_en = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_hold c=%0d got %b want 00000", c, obs);
         end
         next_cycle();
      end
      rst = 1'b0;
      // Gate already high at release must be ignored.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_gate_high c=%0d got %b want 00000", c, obs);
         end
         next_cycle();
      end
      burst_en = 1'b0;
      next_cycle();
      burst_en = 1'b1;
      next_cycle();
      burst_en = 1'b0;
      @(negedge clk);
      obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
      vectors++;
      if (obs !== 5'b10100) begin
         miscompares++;
         $display("FAIL reset_first_start got %b want 10100", obs);
      end
      next_cycle();
      @(negedge clk);
      obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
      vectors++;
      if (obs !== 5'b00001) begin
         miscompares++;
         $display("FAIL reset_first_trunc got %b want 00001", obs);
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_single_byte();
      logic [15:0] word;
      logic [4:0]  obs, exp;
      logic        act;
      word = 16'h5AAA;
      for (int c = 0; c <= 67; c++) begin
         burst_en = 1'b1;
         in_valid = (c <= 32);
         in_data  = 8'h5A;
         act = (c >= 1) && (c <= 64);
         exp = {act, act ? word[(c - 1) / 4] : 1'b0, act && ((c - 1) % 4 == 0),
                (c == 32) || (c == 64), 1'b0};
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL single_byte c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      burst_en = 1'b0;
      in_valid = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [23:0] word;
      logic [4:0]  obs, exp;
      logic        act;
      int          strobes;
      word    = 24'hFF01AA;
      strobes = 0;
      for (int c = 0; c <= 98; c++) begin
         burst_en = 1'b1;
         in_valid = (c <= 64);
         in_data  = (c <= 32) ? 8'h01 : 8'hFF;
         act = (c >= 1) && (c <= 96);
         exp = {act, act ? word[(c - 1) / 4] : 1'b0, act && ((c - 1) % 4 == 0),
                (c == 32) || (c == 64) || (c == 96), 1'b0};
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         if (bit_strobe === 1'b1) strobes++;
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL back_to_back c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      vectors++;
      if (strobes != 24) begin
         miscompares++;
         $display("FAIL back_to_back_strobes got %0d want 24", strobes);
      end
      burst_en = 1'b0;
      in_valid = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_truncation();
      logic [15:0] word;
      logic [7:0]  pre;
      logic [4:0]  obs, exp;
      logic        act1, act2;
      word = 16'h5AAA;
      pre  = 8'hAA;
      for (int c = 0; c <= 59; c++) begin
         burst_en = (c <= 44) || ((c >= 48) && (c <= 55));
         in_valid = (c <= 32);
         in_data  = 8'h5A;
         act1 = (c >= 1) && (c <= 45);
         act2 = (c >= 49) && (c <= 56);
         if (act1) begin
            exp = {1'b1, word[(c - 1) / 4], (c - 1) % 4 == 0, c == 32, 1'b0};
         end else if (act2) begin
            exp = {1'b1, pre[(c - 49) / 4], (c - 49) % 4 == 0, 1'b0, 1'b0};
         end else begin
            exp = {4'b0000, (c == 46) || (c == 57)};
         end
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL truncation c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      burst_en = 1'b0;
      in_valid = 1'b0;
      next_cycle();
   endtask

   task automatic test_guard();
      logic [7:0] pre;
      logic [4:0] obs, exp;
      logic       act1, act2;
      pre = 8'hAA;
      for (int c = 0; c <= 68; c++) begin
         burst_en = (c != 60) && (c <= 65);
         in_valid = 1'b0;
         in_data  = 8'h33;
         act1 = (c >= 1) && (c <= 32);
         act2 = (c >= 62) && (c <= 66);
         if (act1) begin
            exp = {1'b1, pre[(c - 1) / 4], (c - 1) % 4 == 0, c == 32, 1'b0};
         end else if (act2) begin
            exp = {1'b1, pre[(c - 62) / 4], (c - 62) % 4 == 0, 1'b0, 1'b0};
         end else begin
            exp = {4'b0000, c == 67};
         end
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL guard c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      burst_en = 1'b0;
      next_cycle();
   endtask

   task automatic test_rst_mid();
      logic [7:0] pre;
      logic [4:0] obs, exp;
      logic       act;
      pre = 8'hAA;
      for (int c = 0; c <= 20; c++) begin
         burst_en = 1'b1;
         in_valid = 1'b0;
         rst      = (c == 10);
         act = (c >= 1) && (c <= 10);
         exp = act ? {1'b1, pre[(c - 1) / 4], (c - 1) % 4 == 0, 2'b00} : 5'b00000;
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL rst_mid c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      rst      = 1'b0;
      burst_en = 1'b0;
      next_cycle();
      next_cycle();
   endtask

`ifdef BURST_SERIALIZER_CRC_EN
   task automatic test_crc();
      logic [23:0] word;
      logic [4:0]  obs, exp;
      logic        act;
      word = 24'h0701AA;
      for (int c = 0; c <= 98; c++) begin
         burst_en = 1'b1;
         in_valid = (c <= 32);
         in_data  = 8'h01;
         act = (c >= 1) && (c <= 96);
         exp = {act, act ? word[(c - 1) / 4] : 1'b0, act && ((c - 1) % 4 == 0),
                (c == 32) || (c == 64), 1'b0};
         @(negedge clk);
         obs = {tx_active, tx_bit, bit_strobe, in_ready, trunc};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL crc c=%0d got %b want %b", c, obs, exp);
         end
         next_cycle();
      end
      burst_en = 1'b0;
      in_valid = 1'b0;
      next_cycle();
      next_cycle();
   endtask
`endif

   initial begin
      rst      = 1'b1;
      burst_en = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_truncation();
      test_guard();
      test_rst_mid();
`ifdef BURST_SERIALIZER_CRC_EN
      test_crc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
